// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants and palette helpers for the VGA pixel path.
package vga_pkg;
   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = 800;
   localparam int V_DISPLAY = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = 525;
   localparam int RGB_W     = 12;
   localparam int PAL_N     = 16;

   function automatic logic [RGB_W-1:0] gray(input logic [3:0] i);
      return {i, i, i};
   endfunction
endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async reset to a per-lane reset value.
module vga_delay_line
   import vga_pkg::*;
#(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_pixel_pipe.sv
// Framebuffer fetch, double-buffered palette lookup and sync alignment for a
// 160x120 4-bit framebuffer scaled 4x onto a 640x480 display.
module vga_pixel_pipe
   import vga_pkg::*;
#(
   parameter int FB_W        = 160,
   parameter int FB_H        = 120,
   parameter int RD_LAT      = 2,
   parameter int INVERT_SYNC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_hsync,
   input  logic        in_vsync,
   input  logic        in_de,
   input  logic [9:0]  in_x,
   input  logic [9:0]  in_y,
   output logic        fb_rd_en,
   output logic [14:0] fb_addr,
   input  logic [3:0]  fb_rd_data,
   input  logic        pal_wr_en,
   input  logic [3:0]  pal_wr_idx,
   input  logic [11:0] pal_wr_rgb,
   output logic        pal_pending,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        frame_start
);
   localparam int   L      = RD_LAT + 2;
   localparam int   ADDR_W = $clog2(FB_W * FB_H);
   localparam logic INV    = (INVERT_SYNC != 0);

   logic                 rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [RGB_W-1:0]     rgb_q, rgb_d;
   logic                 pend_q, pend_d;
   logic                 vs_prev_q, vs_prev_d;
   logic [RGB_W-1:0]     act_q [PAL_N];
   logic [RGB_W-1:0]     act_d [PAL_N];
   logic [RGB_W-1:0]     shd_q [PAL_N];
   logic [RGB_W-1:0]     shd_d [PAL_N];
   logic [7:0]           x_blk_s, y_blk_s;
   logic                 commit_s;
   logic                 rd_valid_s;
   logic [2:0]           sync_in_s, sync_out_s;

   // Address fetch: row base is y_blk*160 built as (y_blk<<7)+(y_blk<<5).
   always_comb begin
      x_blk_s = in_x[9:2];
      y_blk_s = in_y[9:2];
      rd_en_d = in_de;
      if (in_de) begin
         addr_d = ADDR_W'({y_blk_s, 7'b0000000}) + ADDR_W'({y_blk_s, 5'b00000})
                + ADDR_W'(x_blk_s);
      end else begin
         addr_d = addr_q;
      end
   end

   // Palette update and lookup; commit takes the pre-write shadow.
   always_comb begin
      vs_prev_d = in_vsync;
      commit_s  = in_vsync & ~vs_prev_q & pend_q;
      act_d     = act_q;
      shd_d     = shd_q;
      pend_d    = pend_q;
      if (commit_s) begin
         act_d  = shd_q;
         pend_d = 1'b0;
      end else begin
         act_d  = act_q;
      end
      if (pal_wr_en) begin
         shd_d[pal_wr_idx] = pal_wr_rgb;
         pend_d            = 1'b1;
      end else begin
         shd_d = shd_d;
      end
      if (rd_valid_s) begin
         rgb_d = act_q[fb_rd_data];
      end else begin
         rgb_d = 12'h000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en_q   <= 1'b0;
         addr_q    <= '0;
         rgb_q     <= 12'h000;
         pend_q    <= 1'b0;
         vs_prev_q <= 1'b0;
         for (int i = 0; i < PAL_N; i++) begin
            act_q[i] <= gray(4'(i));
            shd_q[i] <= gray(4'(i));
         end
      end else begin
         rd_en_q   <= rd_en_d;
         addr_q    <= addr_d;
         rgb_q     <= rgb_d;
         pend_q    <= pend_d;
         vs_prev_q <= vs_prev_d;
         act_q     <= act_d;
         shd_q     <= shd_d;
      end
   end

   // Syncs are inverted on entry so the delay line itself holds the output level.
   assign sync_in_s = {in_hsync ^ INV, in_vsync ^ INV,
                       in_de & (in_x == 10'd0) & (in_y == 10'd0)};

   vga_delay_line #(.WIDTH(3), .DEPTH(L), .RST_VAL({INV, INV, 1'b0})) u_sync_dly (
      .clk (clk),
      .rst (rst),
      .d   (sync_in_s),
      .q   (sync_out_s)
   );

   vga_delay_line #(.WIDTH(1), .DEPTH(RD_LAT), .RST_VAL(1'b0)) u_valid_dly (
      .clk (clk),
      .rst (rst),
      .d   (rd_en_q),
      .q   (rd_valid_s)
   );

   assign fb_rd_en    = rd_en_q;
   assign fb_addr     = addr_q;
   assign pal_pending = pend_q;
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];
   assign {vga_hs, vga_vs, frame_start} = sync_out_s;
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed scoreboard bench for vga_pixel_pipe with a 2-cycle framebuffer model.
module tb_vga_pixel_pipe;
   localparam int L = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_hsync = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
   logic [9:0]  in_x = 10'd0, in_y = 10'd0;
   logic        fb_rd_en;
   logic [14:0] fb_addr;
   logic [3:0]  fb_rd_data;
   logic        pal_wr_en = 1'b0;
   logic [3:0]  pal_wr_idx = 4'd0;
   logic [11:0] pal_wr_rgb = 12'h000;
   logic        pal_pending;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, frame_start;

   int          total = 0;
   int          bad = 0;
   int          fb_mode = 0;
   logic [14:0] exp_q [$];
   logic [11:0] act_m [16];
   logic [11:0] shd_m [16];
   logic        pend_m = 1'b0, vsprev_m = 1'b0, exp_rd_en = 1'b0;
   logic [14:0] exp_addr = 15'd0;
   logic [3:0]  fb_p1 = 4'hF, fb_p2 = 4'hF;

   always #5 clk = ~clk;

   vga_pixel_pipe dut (
      .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
      .in_x(in_x), .in_y(in_y), .fb_rd_en(fb_rd_en), .fb_addr(fb_addr),
      .fb_rd_data(fb_rd_data), .pal_wr_en(pal_wr_en), .pal_wr_idx(pal_wr_idx),
      .pal_wr_rgb(pal_wr_rgb), .pal_pending(pal_pending), .vga_r(vga_r), .vga_g(vga_g),
      .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
   );

   function automatic logic [3:0] fb_val(input logic [14:0] a);
      case (fb_mode)
         0:       return 4'd3;
         1:       return a[3:0];
         default: return 4'd4;
      endcase
   endfunction

   // Framebuffer: data appears two cycles after the read strobe; 0xF when idle.
   always @(posedge clk) begin
      fb_p1 <= fb_rd_en ? fb_val(fb_addr) : 4'hF;
      fb_p2 <= fb_p1;
   end
   assign fb_rd_data = fb_p2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_x = 10'd5; in_y = 10'd3;
      pal_wr_en = 1'b0;
      #1;
      chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
      chk("rst_hs", 32'(vga_hs), 32'd1);
      chk("rst_vs", 32'(vga_vs), 32'd1);
      chk("rst_rd_en", 32'(fb_rd_en), 32'd0);
      chk("rst_addr", 32'(fb_addr), 32'd0);
      chk("rst_pend", 32'(pal_pending), 32'd0);
      chk("rst_fs", 32'(frame_start), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      repeat (L) exp_q.push_back({12'h000, 1'b1, 1'b1, 1'b0});
      for (int i = 0; i < 16; i++) begin
         act_m[i] = {4'(i), 4'(i), 4'(i)};
         shd_m[i] = {4'(i), 4'(i), 4'(i)};
      end
      pend_m = 1'b0; vsprev_m = 1'b0; exp_rd_en = 1'b0; exp_addr = 15'd0;
   endtask

   task automatic cyc(input logic de, input int x, input int y, input logic hs,
                      input logic vs, input logic wen = 1'b0, input logic [3:0] widx = 4'd0,
                      input logic [11:0] wrgb = 12'h000);
      logic [14:0] e;
      logic [11:0] rgb_e;
      chk("queue_depth", 32'(exp_q.size()), 32'(L));
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 15'h0;
      chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e[14:3]));
      chk("vga_hs", 32'(vga_hs), 32'(e[2]));
      chk("vga_vs", 32'(vga_vs), 32'(e[1]));
      chk("frame_start", 32'(frame_start), 32'(e[0]));
      chk("fb_rd_en", 32'(fb_rd_en), 32'(exp_rd_en));
      chk("fb_addr", 32'(fb_addr), 32'(exp_addr));
      chk("pal_pending", 32'(pal_pending), 32'(pend_m));
      in_de = de; in_x = 10'(x); in_y = 10'(y); in_hsync = hs; in_vsync = vs;
      pal_wr_en = wen; pal_wr_idx = widx; pal_wr_rgb = wrgb;
      exp_rd_en = de;
      if (de) exp_addr = 15'((y / 4) * 160 + x / 4);
      if (vs && !vsprev_m && pend_m) begin
         act_m = shd_m;
         pend_m = 1'b0;
      end
      if (wen) begin
         shd_m[widx] = wrgb;
         pend_m = 1'b1;
      end
      vsprev_m = vs;
      rgb_e = de ? act_m[fb_val(exp_addr)] : 12'h000;
      exp_q.push_back({rgb_e, ~hs, ~vs, de && x == 0 && y == 0});
      @(negedge clk);
   endtask

   task automatic blank(input int n, input logic hs = 1'b0, input logic vs = 1'b0);
      for (int i = 0; i < n; i++) cyc(1'b0, 700 + i, 500, hs, vs);
   endtask

   task automatic line(input int y, input int x0, input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, x0 + i, y, 1'b0, 1'b0);
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      blank(3);
      fb_mode = 0;
      line(0, 0, 8);
      blank(3, 1'b1, 1'b0);
      blank(2);
      fb_mode = 1;
      line(9, 4, 8);
      cyc(1'b1, 639, 479, 1'b0, 1'b0);
      cyc(1'b1, 636, 478, 1'b0, 1'b0);
      blank(3);
      fb_mode = 0;
      line(1, 0, 3);
      do_reset();
      blank(2);
      line(0, 0, 6);
      for (int i = 0; i < 8; i++) cyc(1'b1, i, 100, 1'b0, 1'b0, i == 2, 4'd3, 12'hF00);
      blank(5);
      blank(3, 1'b0, 1'b1);
      blank(5);
      line(0, 0, 6);
      blank(2);
      cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 4'd3, 12'h0AA);
      cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 4'd3, 12'h00F);
      blank(4);
      cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 4'd4, 12'h0F0);
      blank(2, 1'b0, 1'b1);
      blank(5);
      line(0, 0, 6);
      blank(2);
      fb_mode = 2;
      line(2, 0, 6);
      blank(5);
      blank(2, 1'b0, 1'b1);
      blank(5);
      line(0, 0, 6);
      blank(L + 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
